// File: rtl/au_in_stage.sv
// au_in_stage: issue-side input stage for the arithmetic unit.
// Passes operand selects straight through to the external operand muxes,
// captures the mux outputs with the opcode and destination tag into a
// 2-entry FIFO, and presents the FIFO head to the AU through a
// valid/ready handshake.
// Optional build macro AU_IN_SEL_CHECK_EN: requests that use select 7 are
// flagged illegal. They still complete the request handshake but are
// dropped instead of being queued. The sticky err output reports them.
module au_in_stage #(
  parameter int TAG_W = 6,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_sel_a,
  input  logic [2:0]       req_sel_b,
  input  logic [OP_W-1:0]  req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic [2:0]       sel_a,
  output logic [2:0]       sel_b,
  input  logic [31:0]      din_a,
  input  logic [31:0]      din_b,
  output logic             au_valid,
  input  logic             au_ready,
  output logic [31:0]      au_a,
  output logic [31:0]      au_b,
  output logic [OP_W-1:0]  au_op,
  output logic [TAG_W-1:0] au_tag
`ifdef AU_IN_SEL_CHECK_EN
  ,
  output logic             err
`endif
);

  localparam int DATA_W = 32;

  logic [1:0]        count;
  logic              wr_ptr;
  logic              rd_ptr;
  logic              legal;
  logic              push;
  logic              pop;

  logic [DATA_W-1:0] a_p0   [2];
  logic [DATA_W-1:0] b_p0   [2];
  logic [OP_W-1:0]   op_p0  [2];
  logic [TAG_W-1:0]  tag_p0 [2];

  // Selects go straight to the operand muxes so din_a/din_b settle in the request cycle
  assign sel_a = req_sel_a;
  assign sel_b = req_sel_b;

`ifdef AU_IN_SEL_CHECK_EN
  assign legal = (req_sel_a != 3'd7) && (req_sel_b != 3'd7);
`else
  assign legal = 1'b1;
`endif

  // Ready depends only on registered occupancy, never on au_ready
  assign req_ready = (count != 2'd2);
  assign au_valid  = (count != 2'd0);

  // Illegal requests handshake normally but are not queued
  assign push = req_valid && req_ready && legal;
  assign pop  = au_valid && au_ready;

  // Head outputs are forced to zero while empty, so reset clears them without resetting the data storage
  assign au_a   = au_valid ? a_p0[rd_ptr]   : '0;
  assign au_b   = au_valid ? b_p0[rd_ptr]   : '0;
  assign au_op  = au_valid ? op_p0[rd_ptr]  : '0;
  assign au_tag = au_valid ? tag_p0[rd_ptr] : '0;

  // FIFO occupancy, pointers and error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
`ifdef AU_IN_SEL_CHECK_EN
      err    <= 1'b0;
`endif
    end else begin
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
`ifdef AU_IN_SEL_CHECK_EN
      if (req_valid && req_ready && !legal) err <= 1'b1;
`endif
    end
  end

  // ---- capture stage: mux outputs, opcode and tag written at the write pointer ----
  always_ff @(posedge clk) begin
    if (push) begin
      a_p0[wr_ptr]   <= din_a;
      b_p0[wr_ptr]   <= din_b;
      op_p0[wr_ptr]  <= req_op;
      tag_p0[wr_ptr] <= req_tag;
    end
  end

endmodule

// File: doc/au_in_stage.md
AU_IN_STAGE -- requirements
Module: au_in_stage

Interface
REQ-001 SHALL have parameter TAG_W, default 6, destination-tag width.
REQ-002 SHALL have parameter OP_W, default 4, AU opcode width.
REQ-003 SHALL have port CLK, input, 1: sole clock; all state changes on rising edge.
REQ-004 SHALL have port RST_N, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port REQ_VALID, input, 1: issue request present.
REQ-006 SHALL have port REQ_READY, output, 1: stage can accept a request this cycle.
REQ-007 SHALL have port REQ_SEL_A, input, 3: operand-A source select, 0..6.
REQ-008 SHALL have port REQ_SEL_B, input, 3: operand-B source select, 0..6.
REQ-009 SHALL have port REQ_OP, input, OP_W: AU opcode.
REQ-010 SHALL have port REQ_TAG, input, TAG_W: result destination tag.
REQ-011 SHALL have port SEL_A, output, 3: drives the select of the operand-A input mux.
REQ-012 SHALL have port SEL_B, output, 3: drives the select of the operand-B input mux.
REQ-013 SHALL have port DIN_A, input, 32: operand-A mux output.
REQ-014 SHALL have port DIN_B, input, 32: operand-B mux output.
REQ-015 SHALL have ports AU_VALID (output, 1) and AU_READY (input, 1): AU handshake.
REQ-016 SHALL have ports AU_A and AU_B (output, 32 each), AU_OP (output, OP_W) and AU_TAG (output, TAG_W): issued operation.
REQ-017 SHALL have port ERR, output, 1: sticky illegal-select flag; present only with AU_IN_SEL_CHECK_EN.

Function
REQ-018 SHALL drive SEL_A=REQ_SEL_A and SEL_B=REQ_SEL_B combinationally, with zero latency, so the mux outputs settle within the request cycle.
REQ-019 SHALL accept a request when REQ_VALID&&REQ_READY, capturing {DIN_A, DIN_B, REQ_OP, REQ_TAG} into a 2-entry FIFO on that edge.
REQ-020 SHALL assert REQ_READY iff FIFO count<2; REQ_READY SHALL be registered-state-derived only, with no combinational path from AU_READY.
REQ-021 SHALL drive AU_VALID=(count!=0), with AU_A, AU_B, AU_OP and AU_TAG taken from the head entry, so accept-to-AU_VALID latency is 1 cycle.
REQ-022 SHALL pop the head when AU_VALID&&AU_READY.
REQ-023 SHALL hold the head entry stable while AU_VALID=1 and AU_READY=0.
REQ-024 SHALL, on simultaneous push and pop, keep count unchanged, and at count=2 SHALL NOT accept even if a pop occurs that cycle.
REQ-025 SHALL wrap the read and write pointers modulo 2; count SHALL take only the values 0, 1 or 2.
REQ-026 SHALL deliver operands in strict acceptance order, with no reordering or bypass.

Reset
REQ-027 SHALL, on RST_N=0, immediately clear count, both pointers and ERR, giving AU_VALID=0 and REQ_READY=1.
REQ-028 SHALL, on RST_N=0, drive AU_A, AU_B, AU_OP and AU_TAG to 0.
REQ-029 SHALL discard FIFO contents on a mid-operation reset, with no partial issue after release.
REQ-030 SHALL accept on the first rising edge after RST_N deasserts.

Configuration
REQ-031 SHALL, when macro AU_IN_SEL_CHECK_EN is defined, treat REQ_SEL_A==7 or REQ_SEL_B==7 as illegal.
REQ-032 SHALL, for an illegal request with AU_IN_SEL_CHECK_EN defined, complete the handshake (REQ_READY as normal) but not push it into the FIFO, and SHALL set ERR=1 until reset.
REQ-033 SHALL, when AU_IN_SEL_CHECK_EN is undefined, omit the ERR port, perform no check, and push select 7 requests normally with whatever DIN values are present.

Verification
REQ-034 SHALL cover: single request SEL_A=2, SEL_B=5, DIN_A=0x3F800000, DIN_B=0x40000000, AU_READY=1 -> SEL_A=2 and SEL_B=5 in the same cycle; AU_VALID next cycle carrying those values; one handshake.
REQ-035 SHALL cover: AU_READY=0 with 3 back-to-back requests -> first 2 accepted, REQ_READY=0 on the third; AU_READY=1 -> issue in order (tags 1, 2), then the third accepted.
REQ-036 SHALL cover: count=1 with simultaneous push and pop for 10 cycles -> count stays 1 and tags stay in sequence.
REQ-037 SHALL cover: RST_N pulled low while count=2 -> AU_VALID=0 asynchronously, and no stale issue after release.
REQ-038 SHALL cover, with AU_IN_SEL_CHECK_EN: SEL_B=7 -> ERR=1 next cycle, AU_VALID stays 0, and a following legal request issues normally.
